fir_sm_fifo: RTL and testbench

- Output buffer directly downstream of the FIR engine.
- Accepts the engine's Y stream (sm_tvalid/sm_tdata/sm_tlast) on an AXI-Stream slave port.
- Stores Y beats in a small first-word-fall-through FIFO and re-presents them on an AXI-Stream master port to the consumer or testbench.
- Keeps the engine decoupled from consumer back-pressure, and reports fill level, per-frame beat count and a frame-done pulse for the ap_done logic.

---
 rtl/fir_pkg.sv | 26 ++
 rtl/fir_sm_fifo_mem.sv | 29 ++
 rtl/fir_sm_fifo.sv | 122 ++++++++++++
 tb/tb_fir_sm_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output-side stream buffer: default widths,
// pointer sizing and the packed FIFO entry layout.
package fir_pkg;

  localparam int P_DATA_WIDTH = 32;
  localparam int P_DEPTH      = 8;

  // Elaboration-time ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Index bits plus one wrap bit so that full and empty are distinguishable.
  localparam int P_PTR_WIDTH = clog2(P_DEPTH) + 1;

  typedef struct packed {
    logic                    last;
    logic [P_DATA_WIDTH-1:0] data;
  } entry_t;

endpackage

// File: rtl/fir_sm_fifo_mem.sv
// Register-array storage for the Y FIFO: one synchronous write port and an
// asynchronous read port so the head entry falls through without a cycle.
module fir_sm_fifo_mem
  import fir_pkg::*;
#(
  parameter int pWIDTH = P_DATA_WIDTH + 1,
  parameter int pDEPTH = P_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [clog2(pDEPTH)-1:0]   waddr_i,
  input  logic [pWIDTH-1:0]          wdata_i,
  input  logic [clog2(pDEPTH)-1:0]   raddr_i,
  output logic [pWIDTH-1:0]          rdata_o
);

  logic [pWIDTH-1:0] mem_q [pDEPTH];

  // NOTE: the array is deliberately not reset; an entry is only ever read
  // after it was written, because validity is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_sm_fifo.sv
// First-word-fall-through buffer between the FIR Y stream and its consumer,
// with fill level, per-frame output beat count and a frame-done pulse.
module fir_sm_fifo
  import fir_pkg::*;
#(
  parameter int pDATA_WIDTH = P_DATA_WIDTH,
  parameter int pDEPTH      = P_DEPTH,
  parameter int pCNT_WIDTH  = 10
) (
  input  logic                     axis_clk,
  input  logic                     axis_rst,
  input  logic                     clear,
  input  logic                     s_tvalid,
  input  logic [pDATA_WIDTH-1:0]   s_tdata,
  input  logic                     s_tlast,
  output logic                     s_tready,
  output logic                     m_tvalid,
  output logic [pDATA_WIDTH-1:0]   m_tdata,
  output logic                     m_tlast,
  input  logic                     m_tready,
  output logic [clog2(pDEPTH):0]   level,
  output logic [pCNT_WIDTH-1:0]    beat_cnt,
  output logic                     frame_done
);

  localparam int AW = clog2(pDEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]         FULL_LEVEL = PW'(pDEPTH);
  localparam logic [pCNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef struct packed {
    logic                   last;
    logic [pDATA_WIDTH-1:0] data;
  } fifo_entry_t;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         level_d;
  logic                  s_tready_q, s_tready_d;
  logic [pCNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                  frame_done_q, frame_done_d;

  logic        empty, full, push, pop;
  fifo_entry_t wr_entry, rd_entry;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign push  = s_tvalid && s_tready_q && !full && !clear;
  assign pop   = !empty && m_tready && !clear;

  assign wr_entry = '{last: s_tlast, data: s_tdata};

  fir_sm_fifo_mem #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pDEPTH)
  ) u_mem (
    .clk_i   (axis_clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry)
  );

  // NOTE: every variable gets its default before any branch, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    frame_done_d = 1'b0;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (rd_entry.last) begin
          beat_cnt_d   = '0;
          frame_done_d = 1'b1;
        end else if (beat_cnt_q != CNT_MAX) begin
          beat_cnt_d = beat_cnt_q + pCNT_WIDTH'(1);
        end
      end
    end
    level_d    = wr_ptr_d - rd_ptr_d;
    // Registered ready: looks only at the next fill level, never at m_tready.
    s_tready_d = (level_d != FULL_LEVEL) && !clear;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      s_tready_q   <= 1'b0;
      beat_cnt_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      s_tready_q   <= s_tready_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign s_tready   = s_tready_q;
  assign m_tvalid   = !empty;
  // Head is masked while empty so reset and idle outputs read as zero.
  assign m_tdata    = empty ? '0 : rd_entry.data;
  assign m_tlast    = !empty && rd_entry.last;
  assign level      = wr_ptr_q - rd_ptr_q;
  assign beat_cnt   = beat_cnt_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Directed bench for fir_sm_fifo: a queue-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_fir_sm_fifo;
  import fir_pkg::*;

  localparam int DEPTH = 8;

  logic        axis_clk, axis_rst, clear;
  logic        s_tvalid, s_tlast, s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid, m_tlast, m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  level;
  logic [9:0]  beat_cnt;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  fir_sm_fifo #(.pDATA_WIDTH(32), .pDEPTH(DEPTH), .pCNT_WIDTH(10)) dut (
    .axis_clk   (axis_clk),
    .axis_rst   (axis_rst),
    .clear      (clear),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .m_tvalid   (m_tvalid),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .level      (level),
    .beat_cnt   (beat_cnt),
    .frame_done (frame_done)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, ready/count/done from plain rules.
  entry_t    model_q[$];
  logic      exp_ready;
  int        exp_cnt;
  logic      exp_done;

  always @(posedge axis_clk or posedge axis_rst) begin
    logic do_push, do_pop;
    entry_t head, incoming;
    if (axis_rst) begin
      model_q.delete();
      exp_ready = 1'b0;
      exp_cnt   = 0;
      exp_done  = 1'b0;
    end else if (clear) begin
      model_q.delete();
      exp_ready = 1'b0;
      exp_cnt   = 0;
      exp_done  = 1'b0;
    end else begin
      do_push  = s_tvalid && exp_ready;
      do_pop   = (model_q.size() != 0) && m_tready;
      exp_done = 1'b0;
      if (do_pop) begin
        head = model_q.pop_front();
        if (head.last) begin
          exp_cnt  = 0;
          exp_done = 1'b1;
        end else if (exp_cnt < 1023) begin
          exp_cnt = exp_cnt + 1;
        end
      end
      if (do_push) begin
        incoming.last = s_tlast;
        incoming.data = s_tdata;
        model_q.push_back(incoming);
      end
      exp_ready = (model_q.size() != DEPTH);
    end
  end

  entry_t pop_log[$];
  int     done_count = 0;

  always @(negedge axis_clk) begin
    entry_t e;
    if (axis_rst) begin
      check("rst_s_tready",   s_tready,   0);
      check("rst_m_tvalid",   m_tvalid,   0);
      check("rst_m_tdata",    m_tdata,    0);
      check("rst_m_tlast",    m_tlast,    0);
      check("rst_level",      level,      0);
      check("rst_beat_cnt",   beat_cnt,   0);
      check("rst_frame_done", frame_done, 0);
    end else begin
      check("m_tvalid",   m_tvalid,   model_q.size() != 0);
      check("level",      level,      model_q.size());
      check("s_tready",   s_tready,   exp_ready);
      check("beat_cnt",   beat_cnt,   exp_cnt);
      check("frame_done", frame_done, exp_done);
      if (model_q.size() != 0) begin
        check("m_tdata", m_tdata, model_q[0].data);
        check("m_tlast", m_tlast, model_q[0].last);
      end
      if (frame_done) done_count++;
      if (m_tvalid && m_tready && !clear) begin
        e.last = m_tlast;
        e.data = m_tdata;
        pop_log.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // Holds a beat until the handshake completes, bounded by a cycle budget.
  task automatic send(input logic [31:0] d, input logic last);
    logic acc;
    int   n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    do begin
      acc = s_tready;
      tick();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", n, 0);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (level != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain_done", level, 0);
  endtask

  logic [31:0] vals [3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vals = '{32'h11, 32'h22, 32'h33};
    axis_rst = 1'b1; clear = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;

    // Reset release: ready rises on the first edge after release.
    repeat (3) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    #1 check("ready_before_first_edge", s_tready, 0);
    tick();
    check("ready_after_release", s_tready, 1);
    check("idle_m_tvalid", m_tvalid, 0);
    check("idle_level", level, 0);

    // Back-to-back pushes with a willing consumer: one-cycle fall-through.
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = vals[i];
      s_tlast  = 1'b0;
      tick();
      check("fwft_data", m_tdata, vals[i]);
      check("fwft_level", level, 1);
    end
    s_tvalid = 1'b0;
    tick();
    check("fwft_drained", level, 0);

    // Back-pressure: 8 accepted, ready drops, then all 10 emerge in order.
    m_tready = 1'b0;
    pop_log.delete();
    fork
      begin
        for (int i = 0; i < 10; i++) send(32'h100 + i, 1'b0);
      end
      begin
        repeat (12) @(posedge axis_clk);
        #1;
        check("full_level", level, 8);
        check("full_ready", s_tready, 0);
        m_tready = 1'b1;
      end
    join
    wait_empty();
    check("bp_count", pop_log.size(), 10);
    for (int i = 0; i < 10 && i < pop_log.size(); i++)
      check("bp_order", pop_log[i].data, 32'h100 + i);

    // Frame of five with a randomly stalling consumer.
    pop_log.delete();
    done_count = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(32'h301 + i, i == 4);
      end
      begin
        repeat (25) begin
          m_tready = 1'($urandom_range(0, 1));
          tick();
        end
        m_tready = 1'b1;
      end
    join
    wait_empty();
    tick();
    check("frame_done_pulses", done_count, 1);
    check("frame_pop_count", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      check("frame_tlast", pop_log[i].last, i == 4);
    check("frame_cnt_zero", beat_cnt, 0);

    // Clear at level 4 while a beat is offered.
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h401 + i, 1'b0);
    check("pre_clear_level", level, 4);
    clear = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hAA; s_tlast = 1'b0;
    tick();
    clear = 1'b0; s_tvalid = 1'b0;
    check("clear_level", level, 0);
    check("clear_m_tvalid", m_tvalid, 0);
    check("clear_ready_low", s_tready, 0);
    tick();
    check("clear_ready_back", s_tready, 1);
    m_tready = 1'b1;
    pop_log.delete();
    repeat (3) tick();
    check("clear_no_aa", pop_log.size(), 0);

    // Reset mid-frame at level 3 with one beat already handed out.
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h501 + i, 1'b0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("midframe_level", level, 3);
    check("midframe_cnt", beat_cnt, 1);
    #2 axis_rst = 1'b1;
    #1;
    check("async_rst_m_tvalid", m_tvalid, 0);
    check("async_rst_s_tready", s_tready, 0);
    check("async_rst_level", level, 0);
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
    tick();
    check("post_rst_level", level, 0);
    check("post_rst_cnt", beat_cnt, 0);
    check("post_rst_ready", s_tready, 1);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
